// File: rtl/ex2_stim_seq_pkg.sv
// ex2_stim_seq_pkg: shared state encoding, default hold length and resp slot indexing
package ex2_stim_seq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int HOLD_CYCLES_DEF = 20;
  function automatic int slot_lsb(input int v, input int n_out);
    return v * n_out;
  endfunction
endpackage

// File: rtl/ex2_hold_timer.sv
// ex2_hold_timer: 8-bit hold counter whose terminal count is the sample strobe
module ex2_hold_timer
  import ex2_stim_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] cnt;
  assign tc = en && cnt == 8'(HOLD_CYCLES - 1);
  // count while enabled, restart on clear or at the end of each hold window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr || tc) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/ex2_stim_seq.sv
// ex2_stim_seq: sweeps x through all vectors and captures {f,g,h} into a truth table
module ex2_stim_seq
  import ex2_stim_seq_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int N_OUT       = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          loop_en,
  output logic [N_IN-1:0]               x,
  input  logic                          f_in,
  input  logic                          g_in,
  input  logic                          h_in,
  output logic                          sample,
  output logic                          busy,
  output logic                          done,
  output logic [N_OUT*(2**N_IN)-1:0]    resp
);
  localparam logic [N_IN-1:0] LAST = '1;
  state_t state, state_nxt;
  logic [N_IN-1:0] vec_cnt;
  logic tc, go, last_stop;
  assign go = start && state != ST_RUN;
  assign last_stop = sample && vec_cnt == LAST && !loop_en;
  assign x = vec_cnt;
  ex2_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go),
    .en    (busy),
    .tc    (tc)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  end
  // next state and status outputs; start is only honoured outside RUN
  always_comb begin
    state_nxt = state;
    busy = state == ST_RUN;
    done = state == ST_DONE;
    sample = busy && tc;
    state_nxt = go ? ST_RUN : last_stop ? ST_DONE : state;
  end
  // vector counter and response capture; the last vector holds unless looping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt <= '0;
      resp <= '0;
    end else if (go) begin
      vec_cnt <= '0;
      resp <= '0;
    end else if (sample) begin
      resp[slot_lsb(int'(vec_cnt), N_OUT) +: N_OUT] <= {f_in, g_in, h_in};
      if (vec_cnt != LAST || loop_en) vec_cnt <= vec_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ex2_stim_seq.sv
// tb_ex2_stim_seq: directed sweeps checked against a time-based model plus literal tables
module tb_ex2_stim_seq;
  localparam int H = 20;
  localparam logic [47:0] TBL   = 48'o6774322132212330;
  localparam logic [47:0] TBL_F = 48'o6774766576656774;
  logic clk = 0, rst_n, start, loop_en, f_force;
  logic [3:0] x;
  logic f_in, g_in, h_in, sample, busy, done;
  logic [47:0] resp;
  logic start1;
  logic [3:0] x1v;
  logic sample1, busy1, done1;
  logic [47:0] resp1;
  int errors = 0, checks = 0;
  bit mon = 0;
  always #5 clk = ~clk;
  assign f_in = f_force | (x[3] & x[2]);
  assign g_in = x[1] | x[0];
  assign h_in = ^x;
  ex2_stim_seq #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop_en(loop_en), .x(x),
    .f_in(f_in), .g_in(g_in), .h_in(h_in),
    .sample(sample), .busy(busy), .done(done), .resp(resp)
  );
  ex2_stim_seq #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .loop_en(1'b0), .x(x1v),
    .f_in(x1v[3] & x1v[2]), .g_in(x1v[1] | x1v[0]), .h_in(^x1v),
    .sample(sample1), .busy(busy1), .done(done1), .resp(resp1)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [2:0] resp_of(input int v, input logic ff);
    logic [3:0] b;
    b = 4'(v);
    return {ff | (b[3] & b[2]), b[1] | b[0], ^b};
  endfunction
  bit m_busy, m_done;
  int m_k;
  logic [47:0] m_resp;
  // model: everything follows from the number of RUN cycles since the last start
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_k = 0; m_resp = '0;
    end else if (m_busy) begin
      if (m_k % H == H - 1) begin
        m_resp[3*((m_k/H)%16) +: 3] = resp_of((m_k/H)%16, f_force);
        if ((m_k/H)%16 == 15 && !loop_en) begin
          m_busy = 0; m_done = 1;
        end
      end
      m_k++;
    end else if (start) begin
      m_busy = 1; m_done = 0; m_k = 0; m_resp = '0;
    end
  end
  // compare every cycle away from the active edge
  always @(negedge clk) if (mon) begin
    chk("x", 64'(x), m_busy ? 64'((m_k/H)%16) : m_done ? 64'd15 : 64'd0);
    chk("sample", 64'(sample), 64'(m_busy && (m_k % H == H - 1)));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("resp", 64'(resp), 64'(m_resp));
  end
  task automatic sweep(input int restart_v, input int loop_cyc, output int n);
    bit fired = 0;
    n = 0;
    @(negedge clk) start = 1; loop_en = loop_cyc > 0;
    @(negedge clk) start = 0;
    chk("resp_clr", 64'(resp), 64'd0);
    while (!done && n < 2000) begin
      if (busy) n++;
      if (loop_cyc > 0 && n == loop_cyc) loop_en = 0;
      start = !fired && restart_v >= 0 && busy && x == restart_v[3:0];
      if (start) fired = 1;
      @(negedge clk);
    end
    start = 0;
  endtask
  initial begin
    int n, k, s;
    rst_n = 0; start = 0; start1 = 0; loop_en = 0; f_force = 0;
    repeat (2) @(negedge clk);
    chk("rst_x", 64'(x), 0);
    chk("rst_resp", 64'(resp), 0);
    chk("rst_flags", 64'({sample, busy, done}), 0);
    chk("rst1_flags", 64'({sample1, busy1, done1, x1v}), 0);
    rst_n = 1;
    mon = 1;
    // basic sweep, counting sample pulses alongside
    s = 0;
    fork
      sweep(-1, 0, n);
      begin
        for (int i = 0; i < 400 && !done; i++) begin
          @(posedge clk);
          #1 if (sample) s++;
        end
      end
    join
    chk("sweep_len", 64'(n), 320);
    chk("sample_cnt", 64'(s), 16);
    chk("sweep_tbl", 64'(resp), 64'(TBL));
    chk("done_x", 64'(x), 15);
    // HOLD_CYCLES = 1 instance
    @(negedge clk) start1 = 1;
    @(negedge clk) start1 = 0;
    k = 0;
    while (!done1 && k < 100) begin
      chk("h1_x", 64'(x1v), 64'(k % 16));
      chk("h1_sample", 64'({sample1, busy1}), 64'd3);
      k++;
      @(negedge clk);
    end
    chk("h1_len", 64'(k), 16);
    chk("h1_tbl", 64'(resp1), 64'(TBL));
    // start at vector 7 is ignored
    sweep(7, 0, n);
    chk("restart_len", 64'(n), 320);
    chk("restart_tbl", 64'(resp), 64'(TBL));
    // reset mid-hold at vector 9
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    k = 0;
    while (x != 4'd9 && k < 1000) begin
      k++;
      @(negedge clk);
    end
    chk("reach_v9", 64'(k < 1000), 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("async_rst", 64'({busy, x, resp}), 0);
    @(negedge clk) rst_n = 1;
    sweep(-1, 0, n);
    chk("post_rst_len", 64'(n), 320);
    chk("post_rst_tbl", 64'(resp), 64'(TBL));
    // loop for 40 vectors, stop at the next vector 15
    sweep(-1, 40 * H, n);
    chk("loop_len", 64'(n), 48 * H);
    chk("loop_tbl", 64'(resp), 64'(TBL));
    // restart from DONE with f tied high
    f_force = 1;
    sweep(-1, 0, n);
    chk("force_len", 64'(n), 320);
    chk("force_tbl", 64'(resp), 64'(TBL_F));
    mon = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
